mem_enc: RTL
============

Name: mem_enc

Overview:
- Return-path counterpart of the 2-to-4 memory bank-select decoder.
- Takes one-hot read-return strobes from four memory banks, encodes the active strobe to a 2-bit bank index, and muxes the matching bank's read data.
- Buffers (index, data) pairs in a 2-entry output queue with a valid/ready handshake toward the port controller.
- Flags illegal multi-hot strobes.

Parameters:
- DATA_W, 8, width of each bank's read data and of the output data.
- DEPTH, 2, output queue entries; supported values are 2 and 4 only.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- bank_vld  input  4  per-bank read-return strobe; bit i belongs to bank i; legal patterns are one-hot or zero.
- bank_rdata  input  4*DATA_W  concatenated bank data; bank i occupies bits [i*DATA_W +: DATA_W].
- in_rdy  output  1  high when the queue can accept a return this cycle.
- rd_vld  output  1  queue head valid.
- rd_bank  output  2  encoded bank index of the head entry.
- rd_data  output  DATA_W  data of the head entry.
- rd_rdy  input  1  consumer ready.
- err_multi  output  1  one-cycle pulse on a multi-hot bank_vld.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - queue emptied, pointers cleared.
  - rd_vld=0, rd_bank=0, rd_data=0, err_multi=0, in_rdy=1.
  - Reset during any activity discards all buffered entries and ignores same-cycle bank_vld.
- Encode:
  - 0001->0, 0010->1, 0100->2, 1000->3.
  - Multi-hot is resolved by the highest set bit winning (e.g. 0110->2). err_multi pulses in the following cycle.
  - The entry is still enqueued carrying the highest-index bank's data.
- Accept condition: any bank_vld bit set AND in_rdy=1. The push writes {index, selected data} into the tail entry.
- Dropped returns: bank_vld while in_rdy=0 is dropped and not enqueued; err_multi is not raised for it. Senders must honour in_rdy.
- in_rdy equals (count < DEPTH), registered from the count; it does not depend combinationally on rd_rdy.
- Latency: a push at edge N gives rd_vld=1 after edge N when the queue was empty, i.e. 1 cycle.
- rd_bank and rd_data are driven from the head register. They hold stable while rd_vld=1 and rd_rdy=0.
- Pop condition: rd_vld AND rd_rdy at the edge; the head advances.
- Simultaneous push and pop:
  - When full, the pop happens but the push is rejected, because in_rdy was 0.
  - Otherwise both occur and count is unchanged.
- Order: pointers wrap modulo DEPTH; output is in-order FIFO.
- Empty: rd_vld=0, and rd_bank/rd_data hold their last values (0 after reset).
- Counter: count width is clog2(DEPTH)+1; it never exceeds DEPTH or drops below 0.

Optional Feature:
- Macro MEM_ENC_PARITY_EN.
- When defined:
  - Each queue entry additionally stores an even-parity bit computed over the selected data at push time.
  - Extra output port rd_par (1 bit, reset 0) is presented with the head entry.
  - The bench checks ^{rd_data, rd_par} == 0.
- When undefined: the port and storage are absent, and behaviour is otherwise identical.

Decomposition:
- Package mem_pkg holds:
  - constant NUM_BANKS=4.
  - typedef bank_idx_t (logic [1:0]).
  - function onehot_to_idx (highest-set-bit priority).
  - function is_multihot.
- Sub-module mem_enc_fifo:
  - generic DEPTH x (2+DATA_W[+1]) synchronous FIFO.
  - Interfaces: push/pop, full/empty, count.
- mem_enc top holds the encode/mux logic, the err_multi register, and handshake glue.

Test Plan:
- Reset then single return: bank_vld=0100, bank_rdata bank2=8'hA5, rd_rdy=1 -> next cycle rd_vld=1, rd_bank=2, rd_data=A5; following cycle rd_vld=0.
- All banks in sequence:
  - Stimulus: 0001, 0010, 0100, 1000 on consecutive cycles with data 11, 22, 33, 44; rd_rdy=1.
  - Response: rd_bank 0, 1, 2, 3 with the matching data, in order, one per cycle.
- Backpressure/full:
  - Stimulus: rd_rdy=0, push three returns (data 01, 02, 03).
  - Response: in_rdy=0 after two pushes and the third return is dropped. Raising rd_rdy then yields 01 then 02 only.
- Multi-hot: bank_vld=0110 with bank1=BB, bank2=CC -> err_multi=1 for exactly one cycle; the entry has rd_bank=2, rd_data=CC.
- Simultaneous push/pop when full: queue full, rd_rdy=1, bank_vld=0001 -> one pop, push rejected, count=DEPTH-1, in_rdy=1 the next cycle.
- Reset mid-operation: queue holding 2 entries, rst=1 for one edge with bank_vld=1000 -> rd_vld=0, in_rdy=1, no entry from that cycle appears afterward.

Source files
------------

// File: rtl/mem_pkg.sv
// ============================================================================
// Module : mem_pkg
// Brief  : Shared constants, bank index type and strobe encode helpers for
//          the memory read-return encoder.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int NUM_BANKS = 4;

    typedef logic [1:0] bank_idx_t;

    // Highest set bit wins so that multi-hot strobes resolve deterministically.
    function automatic bank_idx_t onehot_to_idx(input logic [NUM_BANKS-1:0] vld);
        bank_idx_t idx;
        idx = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (vld[i]) begin
                idx = bank_idx_t'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic is_multihot(input logic [NUM_BANKS-1:0] vld);
        return ($countones(vld) > 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_enc_fifo.sv
// ============================================================================
// Module : mem_enc_fifo
// Brief  : Generic DEPTH x WIDTH synchronous FIFO with a registered head that
//          holds its last value while empty.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_enc_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int               c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]    c_FULL = (c_AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wptr;
    logic [c_AW-1:0]  r_rptr;
    logic [c_AW:0]    r_count;
    logic [WIDTH-1:0] r_dout;

    logic             w_push;
    logic             w_pop;
    logic [c_AW-1:0]  w_rptr_nxt;
    logic [c_AW:0]    w_count_pop;
    logic [c_AW:0]    w_count_nxt;

    assign o_full  = (r_count == c_FULL);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_dout;

    assign w_push      = i_push && !o_full;
    assign w_pop       = i_pop && !o_empty;
    assign w_rptr_nxt  = r_rptr + c_AW'(w_pop);
    assign w_count_pop = r_count - (c_AW+1)'(w_pop);
    assign w_count_nxt = w_count_pop + (c_AW+1)'(w_push);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    // The head register is loaded with whatever entry will sit at the read
    // pointer after this edge; a push into an otherwise-empty queue bypasses
    // the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_dout  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_AW'(1);
            end
            r_rptr  <= w_rptr_nxt;
            r_count <= w_count_nxt;
            if (w_push && (w_count_pop == '0)) begin
                r_dout <= i_din;
            end else if (w_count_nxt != '0) begin
                r_dout <= r_mem[w_rptr_nxt];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_enc.sv
// ============================================================================
// Module : mem_enc
// Brief  : Encodes one-hot bank read-return strobes to a bank index, muxes the
//          bank data and queues (index, data) toward the port controller.
//          Optional even-parity storage/output enabled by MEM_ENC_PARITY_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_enc
    import mem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_BANKS-1:0]        bank_vld,
    input  logic [NUM_BANKS*DATA_W-1:0] bank_rdata,
    output logic                        in_rdy,
    output logic                        rd_vld,
    output bank_idx_t                   rd_bank,
    output logic [DATA_W-1:0]           rd_data,
    input  logic                        rd_rdy,
`ifdef MEM_ENC_PARITY_EN
    output logic                        rd_par,
`endif
    output logic                        err_multi
);

`ifdef MEM_ENC_PARITY_EN
    localparam int c_ENTRY_W = 2 + DATA_W + 1;
`else
    localparam int c_ENTRY_W = 2 + DATA_W;
`endif
    localparam int                      c_CW        = $clog2(DEPTH) + 1;
    localparam logic [c_CW-1:0]         c_DEPTH_CNT = c_CW'(DEPTH);

    bank_idx_t            w_idx;
    logic [DATA_W-1:0]    w_sel_data;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [c_CW-1:0]      w_count;
    logic [c_ENTRY_W-1:0] w_din;
    logic [c_ENTRY_W-1:0] w_dout;
    logic                 r_err_multi;

    assign w_idx      = onehot_to_idx(bank_vld);
    assign w_sel_data = bank_rdata[w_idx*DATA_W +: DATA_W];

    assign in_rdy = !w_full;
    assign rd_vld = !w_empty;
    assign w_push = (bank_vld != '0) && in_rdy;
    assign w_pop  = rd_vld && rd_rdy;

`ifdef MEM_ENC_PARITY_EN
    // Even parity: the XOR of data and parity bit is zero.
    assign w_din   = {w_idx, w_sel_data, ^w_sel_data};
    assign rd_bank = w_dout[c_ENTRY_W-1 -: 2];
    assign rd_data = w_dout[DATA_W:1];
    assign rd_par  = w_dout[0];
`else
    assign w_din   = {w_idx, w_sel_data};
    assign rd_bank = w_dout[c_ENTRY_W-1 -: 2];
    assign rd_data = w_dout[DATA_W-1:0];
`endif

    mem_enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_din),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // Dropped returns (in_rdy low) never raise the error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_multi <= 1'b0;
        end else begin
            r_err_multi <= w_push && is_multihot(bank_vld);
        end
    end

    assign err_multi = r_err_multi;

    a_count_bound: assert property (@(posedge clk) disable iff (rst) w_count <= c_DEPTH_CNT);

endmodule

`default_nettype wire
